ov5640_dvp_gen: RTL and testbench

Synthetic OV5640-style DVP camera source: it drives vsync, href and 8-bit byte data exactly as the sensor does in RGB565 output mode, two bytes per pixel, high byte first. The block stands in for the physical sensor on the transmit side of the DVP capture path. Uses: simulation stimulus, board bring-up without a camera, and built-in self-test of the capture/SDRAM write chain. One byte is output per `sys_clk`, so downstream capture logic clocks on the same edge as its pixel clock.

---
 rtl/ov5640_dvp_gen.sv | 152 +++++++++++++++
 tb/tb_ov5640_dvp_gen.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov5640_dvp_gen.sv
// ov5640_dvp_gen: synthetic OV5640-style RGB565 DVP source (vsync/href/byte data, one byte per clock)
module ov5640_dvp_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 64,
  parameter int VSYNC_W  = 4,
  parameter int V_BP     = 2,
  parameter int V_FP     = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       gen_en,
  input  logic [1:0] pattern_sel,
  output logic       dvp_vsync,
  output logic       dvp_href,
  output logic [7:0] dvp_data,
  output logic       frame_done,
  output logic       busy
);
  localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam logic [15:0] H_LAST = 16'(LINE_LEN - 1);
  localparam logic [15:0] H_ACT_B = 16'(2 * H_ACTIVE);
  localparam int BW = $clog2(H_ACTIVE);
  localparam logic [BW-1:0] BAR_LAST = BW'(H_ACTIVE / 8 - 1);

  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACT, VFP} st_t;

  function automatic logic [15:0] lines(st_t s);
    return s == VSYNC ? 16'(VSYNC_W) : s == VBP ? 16'(V_BP) : s == ACT ? 16'(V_ACTIVE) : s == VFP ? 16'(V_FP) : 16'd0;
  endfunction

  // first state after s that has at least one line; IDLE means the frame ends after s
  function automatic st_t after(st_t s);
    st_t r = IDLE;
    for (int i = 4; i >= 1; i--)
      if (i > int'(s) && lines(st_t'(3'(i))) != 16'd0) r = st_t'(3'(i));
    return r;
  endfunction

  function automatic logic [15:0] bar_rgb(logic [2:0] b);
    case (b)
      3'd0: return 16'hFFFF;
      3'd1: return 16'hFFE0;
      3'd2: return 16'h07FF;
      3'd3: return 16'h07E0;
      3'd4: return 16'hF81F;
      3'd5: return 16'hF800;
      3'd6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  st_t st_q, st_d;
  logic [15:0] h_q, h_d, v_q, v_d;
  logic end_line, end_state, frame_end, start;
  logic [7:0] fc_q, fc_use, lo_q;
  logic [1:0] pat_q, pat_use;
  logic [15:0] pcnt_q, pcnt_use, pix;
  logic [2:0] bar_q, bar_use;
  logic [BW-1:0] bpos_q, bpos_use;
  logic vsync_q, vsync_d, href_q, href_d, hi_d, done_q, done_d, busy_q, busy_d;
  logic [7:0] data_q, data_d;

  // FSM state and line/column position register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      st_q <= IDLE;
      h_q <= '0;
      v_q <= '0;
    end else begin
      st_q <= st_d;
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // next position: gen_en is only consulted in IDLE or on the last cycle of a frame
  always_comb begin
    end_line = h_q == H_LAST;
    end_state = end_line && v_q == lines(st_q) - 16'd1;
    frame_end = st_q != IDLE && end_state && after(st_q) == IDLE;
    st_d = st_q;
    h_d = h_q + 16'd1;
    v_d = v_q;
    if (st_q == IDLE || frame_end) begin
      st_d = gen_en ? after(IDLE) : IDLE;
      h_d = '0;
      v_d = '0;
    end else if (end_state) begin
      st_d = after(st_q);
      h_d = '0;
      v_d = '0;
    end else if (end_line) begin
      h_d = '0;
      v_d = v_q + 16'd1;
    end
    start = (st_q == IDLE || frame_end) && st_d != IDLE;
  end

  // outputs for the upcoming position; per-frame values bypass their registers on the start cycle
  always_comb begin
    fc_use = start ? fc_q + 8'd1 : fc_q;
    pat_use = start ? pattern_sel : pat_q;
    pcnt_use = start ? 16'd0 : pcnt_q;
    bar_use = h_d == 16'd0 ? 3'd0 : bar_q;
    bpos_use = h_d == 16'd0 ? '0 : bpos_q;
    pix = pat_use == 2'd1 ? pcnt_use : pat_use == 2'd2 ? {fc_use, fc_use} : bar_rgb(bar_use);
    vsync_d = st_d == VSYNC;
    href_d = st_d == ACT && h_d < H_ACT_B;
    hi_d = !h_d[0];
    data_d = !href_d ? 8'd0 : hi_d ? pix[15:8] : lo_q;
    done_d = st_d != IDLE && h_d == H_LAST && v_d == lines(st_d) - 16'd1 && after(st_d) == IDLE;
    busy_d = st_d != IDLE;
  end

  // output registers, frame latches and pixel/bar counters (advanced on each high byte)
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      {vsync_q, href_q, done_q, busy_q} <= '0;
      data_q <= '0;
      fc_q <= '0;
      pat_q <= '0;
      pcnt_q <= '0;
      lo_q <= '0;
      bar_q <= '0;
      bpos_q <= '0;
    end else begin
      vsync_q <= vsync_d;
      href_q <= href_d;
      data_q <= data_d;
      done_q <= done_d;
      busy_q <= busy_d;
      if (start) begin
        fc_q <= fc_use;
        pat_q <= pattern_sel;
        pcnt_q <= '0;
      end
      if (href_d && hi_d) begin
        pcnt_q <= pcnt_use + 16'd1;
        lo_q <= pix[7:0];
        bpos_q <= bpos_use == BAR_LAST ? '0 : bpos_use + BW'(1);
        bar_q <= bpos_use == BAR_LAST ? bar_use + 3'd1 : bar_use;
      end
    end
  end

  assign dvp_vsync = vsync_q;
  assign dvp_href = href_q;
  assign dvp_data = data_q;
  assign frame_done = done_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_ov5640_dvp_gen.sv
// tb_ov5640_dvp_gen: randomized self-checking bench for ov5640_dvp_gen against a frame-position model
module tb_ov5640_dvp_gen;
  localparam int HA = 8, VA = 4, HB = 4, VSW = 1, VBP = 1, VFP = 1;
  localparam int LL = 2 * HA + HB;
  localparam int FRAME = (VSW + VBP + VA + VFP) * LL;
  localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  localparam logic [7:0] BARB [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                       8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

  logic clk = 0, rst = 1, gen_en = 0;
  logic [1:0] psel = 0;
  logic vsync, href, done, busy;
  logic [7:0] data;
  logic [11:0] obs, exp_v;
  int nchk = 0, nfail = 0;
  int mt = -1;
  logic [7:0] mfc = 0;
  logic [1:0] mpat = 0;

  ov5640_dvp_gen #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .VSYNC_W(VSW), .V_BP(VBP), .V_FP(VFP)) dut (
    .sys_clk(clk), .sys_rst(rst), .gen_en(gen_en), .pattern_sel(psel),
    .dvp_vsync(vsync), .dvp_href(href), .dvp_data(data), .frame_done(done), .busy(busy)
  );

  always #5 clk = ~clk;
  assign obs = {vsync, href, data, done, busy};

  // expected outputs from the position t within a frame (-1 = idle)
  function automatic logic [11:0] model(int t, logic [7:0] fc, logic [1:0] pat);
    int line, h, x, y;
    logic hr;
    logic [15:0] pix;
    logic [7:0] d;
    if (t < 0) return 12'd0;
    line = t / LL;
    h = t % LL;
    x = h / 2;
    y = line - VSW - VBP;
    hr = y >= 0 && y < VA && h < 2 * HA;
    pix = pat == 2'd1 ? 16'(y * HA + x) : pat == 2'd2 ? {fc, fc} : BARS[(x / (HA / 8)) % 8];
    d = !hr ? 8'd0 : (h % 2 == 0) ? pix[15:8] : pix[7:0];
    return {line < VSW, hr, d, t == FRAME - 1, 1'b1};
  endfunction

  always_comb exp_v = model(mt, mfc, mpat);

  // frame position tracker: frames start only from idle or right after a frame's last cycle
  always @(posedge clk) begin
    if (rst) begin
      mt <= -1;
      mfc <= 8'd0;
    end else if (mt == -1 || mt == FRAME - 1) begin
      if (gen_en) begin
        mt <= 0;
        mfc <= mfc + 8'd1;
        mpat <= psel;
      end else mt <= -1;
    end else mt <= mt + 1;
  end

  task automatic restart(input logic [1:0] p);
    @(negedge clk);
    rst = 1;
    gen_en = 1;
    psel = p;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    int hi_cnt = 0;
    @(negedge clk);
    rst = 1;
    gen_en = 1;
    psel = 0;
    repeat (4) begin
      @(negedge clk);
      nchk++;
      if (obs !== 12'd0) begin nfail++; $display("FAIL reset_hold: got %h expected 000", obs); end
    end
    rst = 0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      nchk++;
      if (vsync !== 1'(c <= 20)) begin nfail++; $display("FAIL reset_vsync c=%0d: got %b expected %b", c, vsync, c <= 20); end
      hi_cnt += int'(vsync);
    end
    nchk++;
    if (hi_cnt != 20) begin nfail++; $display("FAIL reset_vsync_len: got %0d expected 20", hi_cnt); end
  endtask

  task automatic test_frames();
    int rises = 0, run = 0, gap = 0, dones = 0, last_vs = 0;
    logic prev_h = 0, prev_v = 0;
    restart(2'($urandom_range(0, 3)));
    for (int c = 1; c <= 3 * FRAME + 2; c++) begin
      @(negedge clk);
      nchk++;
      if (obs !== exp_v) begin nfail++; $display("FAIL frame_model c=%0d: got %h expected %h", c, obs, exp_v); end
      if (href) run++;
      if (href && !prev_h) begin
        rises++;
        if (rises % 4 != 1) begin
          nchk++;
          if (gap != HB) begin nfail++; $display("FAIL href_gap c=%0d: got %0d expected %0d", c, gap, HB); end
        end
      end
      if (!href && prev_h) begin
        nchk++;
        if (run != 2 * HA) begin nfail++; $display("FAIL href_len c=%0d: got %0d expected %0d", c, run, 2 * HA); end
        run = 0;
        gap = 0;
      end
      if (!href) gap++;
      if (done) begin
        nchk++;
        if (c != FRAME * (dones + 1)) begin nfail++; $display("FAIL done_time: got %0d expected %0d", c, FRAME * (dones + 1)); end
        dones++;
      end
      if (vsync && !prev_v) begin
        if (c > 1) begin
          nchk++;
          if (c - last_vs != FRAME) begin nfail++; $display("FAIL vsync_period: got %0d expected %0d", c - last_vs, FRAME); end
        end
        last_vs = c;
      end
      prev_h = href;
      prev_v = vsync;
      psel = 2'($urandom_range(0, 3));
    end
    nchk++;
    if (rises != 3 * VA) begin nfail++; $display("FAIL href_count: got %0d expected %0d", rises, 3 * VA); end
    nchk++;
    if (dones != 3) begin nfail++; $display("FAIL done_count: got %0d expected 3", dones); end
  endtask

  task automatic test_bars();
    int k = 0;
    restart(2'd0);
    for (int c = 1; c <= FRAME; c++) begin
      @(negedge clk);
      if (href) begin
        nchk++;
        if (data !== BARB[k % 16]) begin nfail++; $display("FAIL bars k=%0d: got %h expected %h", k, data, BARB[k % 16]); end
        k++;
      end
    end
    nchk++;
    if (k != 4 * 2 * HA) begin nfail++; $display("FAIL bars_bytes: got %0d expected %0d", k, 8 * HA); end
  endtask

  task automatic test_counter();
    int k = 0;
    logic [15:0] tail = 0;
    logic [7:0] e;
    restart(2'd1);
    for (int c = 1; c <= FRAME; c++) begin
      @(negedge clk);
      if (href) begin
        e = (k % 2 == 1) ? 8'((k / 2) & 255) : 8'((k / 2) >> 8);
        nchk++;
        if (data !== e) begin nfail++; $display("FAIL counter k=%0d: got %h expected %h", k, data, e); end
        tail = {tail[7:0], data};
        k++;
      end
    end
    nchk++;
    if (tail !== 16'h001F) begin nfail++; $display("FAIL counter_tail: got %h expected 001f", tail); end
  endtask

  task automatic test_latch_stop();
    int k = 0;
    restart(2'd1);
    for (int c = 1; c <= FRAME + 6; c++) begin
      @(negedge clk);
      nchk++;
      if (obs !== exp_v) begin nfail++; $display("FAIL latch_model c=%0d: got %h expected %h", c, obs, exp_v); end
      if (c == FRAME) begin
        nchk++;
        if (done !== 1'b1) begin nfail++; $display("FAIL stop_done: got %b expected 1", done); end
      end
      if (c == FRAME + 1) begin
        nchk++;
        if (busy !== 1'b0) begin nfail++; $display("FAIL stop_busy: got %b expected 0", busy); end
      end
      if (c == 50) psel = 2'd2;
      if (c == 80) gen_en = 0;
    end
    gen_en = 1;
    for (int c = 1; c <= FRAME + 1; c++) begin
      @(negedge clk);
      if (href) begin
        nchk++;
        if (data !== 8'd2) begin nfail++; $display("FAIL solid k=%0d: got %h expected 02", k, data); end
        k++;
      end
    end
    nchk++;
    if (k != 8 * HA) begin nfail++; $display("FAIL solid_bytes: got %0d expected %0d", k, 8 * HA); end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    logic [7:0] e;
    restart(2'd2);
    for (int c = 1; c <= FRAME + 2 * LL + 5; c++) begin
      @(negedge clk);
      nchk++;
      if (obs !== exp_v) begin nfail++; $display("FAIL mid_model c=%0d: got %h expected %h", c, obs, exp_v); end
    end
    rst = 1;
    @(negedge clk);
    nchk++;
    if (obs !== 12'd0) begin nfail++; $display("FAIL mid_reset: got %h expected 000", obs); end
    rst = 0;
    for (int c = 1; c <= FRAME; c++) begin
      @(negedge clk);
      nchk++;
      if (vsync !== 1'(c <= LL)) begin nfail++; $display("FAIL mid_vsync c=%0d: got %b", c, vsync); end
      if (href) begin
        nchk++;
        if (data !== 8'd1) begin nfail++; $display("FAIL mid_fcnt: got %h expected 01", data); end
      end
    end
    psel = 2'd1;
    repeat (50) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    for (int c = 1; c <= FRAME; c++) begin
      @(negedge clk);
      if (href) begin
        e = (k % 2 == 1) ? 8'((k / 2) & 255) : 8'((k / 2) >> 8);
        nchk++;
        if (data !== e) begin nfail++; $display("FAIL mid_counter k=%0d: got %h expected %h", k, data, e); end
        k++;
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      nchk++;
      if (obs !== exp_v) begin nfail++; $display("FAIL random c=%0d: got %h expected %h", c, obs, exp_v); end
      psel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) gen_en = ~gen_en;
      rst = $urandom_range(0, 499) == 0;
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_frames();
    test_bars();
    test_counter();
    test_latch_stop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
